uart_dtp_tx: RTL and testbench
==============================

Name: uart_dtp_tx

Overview:
Parallel-to-serial UART transmitter (DTP) at the far end of the TX_RDY_T / TX_DATA_T / TX_RDY_R handshake driven by the message FSM. It accepts one byte per handshake, stores it in a shadow register, and serialises it on TXD as start, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits. Baud timing comes from an internal clock-enable divider. Output TXD drives the board UART pin.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD, 115200, line bit rate in bit/s.
DIV, CLK_FREQ/BAUD (integer division), clocks per bit; must be >= 2; sized counter width = clog2(DIV).
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2 stop bits.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-high reset.
TX_RDY_T  input  1  level: sender has a valid byte on TX_DATA_T; may stay high across a multi-byte message.
TX_DATA_T  input  8  byte to transmit; sampled only on accept.
TX_RDY_R  output  1  one-clock pulse: byte accepted and latched; sender may present the next byte.
TXD  output  1  serial line, idle high.
BUSY  output  1  high while a frame is on the line (START through last STOP).

Behaviour:
- Reset values (asynchronous, immediate): TXD=1, TX_RDY_R=0, BUSY=0, state IDLE, bit and baud counters 0, shadow register 0x00.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: TXD=1. When TX_RDY_T=1 at an edge: latch TX_DATA_T into the shadow register, TX_RDY_R=1 for exactly the next cycle, go to START, clear the baud counter, BUSY=1. Latency is 1 clock from TX_RDY_T sampled high to TXD falling.
- Each of START, DATA (8 bits), PAR, and each STOP bit holds TXD for exactly DIV clocks. The baud counter counts 0..DIV-1. The terminal count advances the bit.
- START: TXD=0.
- DATA: TXD=shadow[bit_ct], bit_ct 0..7. After bit 7, go to PAR if PARITY!=0, else go to STOP.
- PAR: TXD = XOR of shadow for even parity, or its inverse for odd parity.
- STOP: TXD=1 for STOP_BITS*DIV clocks.
- End of the last stop bit:
  - If TX_RDY_T=1: accept the next byte in the same cycle, as in IDLE (TX_RDY_R pulse, go to START). No idle gap between frames.
  - Otherwise go to IDLE and set BUSY=0.
- TX_RDY_T is ignored outside IDLE and the final stop-bit terminal cycle. Dropping TX_RDY_T mid-frame never aborts the frame.
- TX_DATA_T changes after accept do not affect the frame in progress.
- Exactly one TX_RDY_R pulse per accepted byte. TX_RDY_R is never high for two consecutive cycles.
- Frame length = DIV*(10 + (PARITY!=0) + (STOP_BITS-1)) clocks.
- RST asserted mid-frame: TXD forced to 1 immediately and the frame is lost. After release, the block waits in IDLE for TX_RDY_T. No TX_RDY_R is generated by the reset itself.
- TX_RDY_T high while RST is high: no accept. The first accept happens at the first edge after RST falls.
- TXD is driven from a register (glitch-free).

Test Plan:
- Bench parameters for all scenarios: CLK_FREQ=1000, BAUD=100 (DIV=10).
- Reset idle: RST pulse with TX_RDY_T=0 -> TXD=1, TX_RDY_R=0, BUSY=0. Hold TXD=1 for 200 clocks.
- Single byte, PARITY=0, STOP_BITS=1: TX_RDY_T=1 with 0xA5 for one accept, then TX_RDY_T=0.
  - TX_RDY_R is a single 1-cycle pulse.
  - TXD sequence (10 clocks each): 0, 1,0,1,0,0,1,0,1, 1.
  - BUSY is high for 100 clocks, then returns to IDLE.
- Even parity, PARITY=1, byte 0x55: frame is 0,1,0,1,0,1,0,1,0, parity 0, stop 1, for 110 clocks total. With PARITY=2, the parity bit is 1.
- Back-to-back message: sender holds TX_RDY_T=1 and on each TX_RDY_R pulse changes data through 0x0D, 0x0A, then drops TX_RDY_T.
  - Two frames are sent with no idle gap.
  - Exactly two TX_RDY_R pulses, 100 clocks apart.
  - The second frame carries 0x0A.
- Data change and RDY drop mid-frame: accept 0x3C, then at clock 30 set TX_DATA_T=0xFF and TX_RDY_T=0 -> the full 0x3C frame is still transmitted and no second accept occurs.
- Reset mid-frame: assert RST at clock 45 of a 0x00 frame -> TXD goes 1 asynchronously and BUSY=0. After release with TX_RDY_T=1 and data 0x81, a fresh, complete 0x81 frame is sent.

Source files
------------

// File: rtl/uart_dtp_tx.sv
// Byte-at-a-time UART transmitter: latches a byte on the TX_RDY_T/TX_RDY_R
// handshake and shifts it out as start, 8 data LSB-first, optional parity, stop(s).
module uart_dtp_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TX_RDY_T,
    input  logic [7:0] TX_DATA_T,
    output logic       TX_RDY_R,
    output logic       TXD,
    output logic       BUSY
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] baud_ct, baud_nxt;
    logic [2:0]    bit_ct, bit_nxt;
    logic [7:0]    shadow, shadow_nxt;
    logic          txd_nxt, rdy_nxt, busy_nxt;
    logic          tick, last_stop, accept;

    assign tick      = (baud_ct == CW'(DIV - 1));
    assign last_stop = (bit_ct == 3'(STOP_BITS - 1));
    // A new byte is taken in IDLE or on the very last clock of the final stop bit.
    assign accept    = TX_RDY_T && ((state == IDLE) || (state == STOP && tick && last_stop));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            baud_ct  <= '0;
            bit_ct   <= '0;
            shadow   <= '0;
            TXD      <= 1'b1;
            TX_RDY_R <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_ct  <= baud_nxt;
            bit_ct   <= bit_nxt;
            shadow   <= shadow_nxt;
            TXD      <= txd_nxt;
            TX_RDY_R <= rdy_nxt;
            BUSY     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = START;
            START: if (tick) state_nxt = DATA;
            DATA:  if (tick && bit_ct == 3'd7) state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:   if (tick) state_nxt = STOP;
            STOP:  if (tick && last_stop) state_nxt = accept ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // TXD is computed from the next state so the registered line changes on the
    // same edge as the state it represents.
    always_comb begin
        baud_nxt   = (state == IDLE || tick) ? '0 : baud_ct + 1'b1;
        bit_nxt    = (state_nxt != state) ? 3'd0 : (tick ? bit_ct + 3'd1 : bit_ct);
        shadow_nxt = accept ? TX_DATA_T : shadow;
        rdy_nxt    = accept;
        busy_nxt   = (state_nxt != IDLE);
        case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = shadow_nxt[bit_nxt];
            PAR:     txd_nxt = (PARITY == 2) ? ~(^shadow) : ^shadow;
            default: txd_nxt = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_dtp_tx.sv
// Bench for uart_dtp_tx: four instances (none/even/odd parity, two stop bits),
// a frame scoreboard per instance and directed plus random byte streams.
module tb_uart_dtp_tx;
    localparam int DIV = 10;
    localparam int NI  = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       rdy_t [NI];
    logic [7:0] data_t[NI];
    logic       rdy_r [NI];
    logic       txd   [NI];
    logic       busy  [NI];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses[NI];
    logic [7:0] exp_q[NI][$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic int par_of(input int u);
        return (u == 3) ? 0 : u;
    endfunction

    function automatic int frame_bits(input int u);
        return 10 + ((par_of(u) != 0) ? 1 : 0) + ((u == 3) ? 1 : 0);
    endfunction

    // Line level of bit slot k of a frame carrying byte b on instance u.
    function automatic logic ref_bit(input int u, input logic [7:0] b, input int k);
        int ones = 0;
        int p = par_of(u);
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && p != 0) return (p == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
        return 1'b1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : u
        localparam int P = (g == 3) ? 0 : g;
        localparam int S = (g == 3) ? 2 : 1;

        uart_dtp_tx #(.CLK_FREQ(1000), .BAUD(100), .PARITY(P), .STOP_BITS(S)) dut (
            .CLK(CLK), .RST(RST), .TX_RDY_T(rdy_t[g]), .TX_DATA_T(data_t[g]),
            .TX_RDY_R(rdy_r[g]), .TXD(txd[g]), .BUSY(busy[g])
        );

        initial begin : mon
            logic [7:0] b;
            int nb, badk;
            bit ok, ab;
            forever begin
                @(negedge CLK);
                if (!RST && txd[g] === 1'b0) begin
                    ok = 1; ab = 0; badk = -1; b = 8'h00;
                    if (exp_q[g].size() == 0) chk(0, $sformatf("unexpected_frame_u%0d", g), 1, 0);
                    else b = exp_q[g].pop_front();
                    nb = frame_bits(g) * DIV;
                    for (int k = 0; k < nb; k++) begin
                        if (k > 0) @(negedge CLK);
                        if (RST) begin ab = 1; break; end
                        if (txd[g] !== ref_bit(g, b, k / DIV) || busy[g] !== 1'b1) begin
                            if (ok) badk = k;
                            ok = 0;
                        end
                    end
                    if (!ab) chk(ok, $sformatf("frame_u%0d_byte%02h_first_bad_clk", g, b), badk, -1);
                end else begin
                    chk(txd[g] === 1'b1 && busy[g] === 1'b0, $sformatf("idle_u%0d_busy", g),
                        int'(busy[g]), 0);
                end
            end
        end

        initial begin : rmon
            logic prev;
            prev = 1'b0;
            forever begin
                @(negedge CLK);
                if (rdy_r[g] === 1'b1) begin
                    chk(!prev, $sformatf("rdy_double_u%0d", g), 1, 0);
                    pulses[g]++;
                end
                prev = (rdy_r[g] === 1'b1);
            end
        end
    end

    task automatic wait_pulse(input int ui, output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (rdy_r[ui] === 1'b1) begin at = cyc; break; end
        end
        chk(at >= 0, $sformatf("rdy_wait_u%0d", ui), at, 0);
        if (at >= 0) chk(txd[ui] === 1'b0, $sformatf("start_with_rdy_u%0d", ui), int'(txd[ui]), 0);
    endtask

    task automatic accept_byte(input int ui, input logic [7:0] b, output int at);
        data_t[ui] = b;
        rdy_t[ui]  = 1'b1;
        exp_q[ui].push_back(b);
        wait_pulse(ui, at);
    endtask

    task automatic rand_run(input int ui);
        int a, p0;
        bit hold;
        p0 = pulses[ui];
        for (int n = 0; n < 6; n++) begin
            accept_byte(ui, 8'($urandom), a);
            hold = 1'($urandom_range(0, 1));
            if (!hold || n == 5) begin
                rdy_t[ui] = 1'b0;
                repeat ($urandom_range(0, 30)) @(negedge CLK);
            end
        end
        repeat (150) @(negedge CLK);
        chk(pulses[ui] - p0 == 6, $sformatf("rand_pulses_u%0d", ui), pulses[ui] - p0, 6);
    endtask

    initial begin
        int a, a1, a2, c, p0;
        logic pre;
        RST = 1'b1;
        for (int i = 0; i < NI; i++) begin
            rdy_t[i] = 1'b0; data_t[i] = 8'h00;
        end
        repeat (3) @(negedge CLK);
        for (int i = 0; i < NI; i++)
            chk(txd[i] === 1'b1 && rdy_r[i] === 1'b0 && busy[i] === 1'b0,
                $sformatf("reset_state_u%0d", i), int'({txd[i], rdy_r[i], busy[i]}), 4);
        RST = 1'b0;
        repeat (200) @(negedge CLK);
        for (int i = 0; i < NI; i++)
            chk(txd[i] === 1'b1 && pulses[i] == 0, $sformatf("idle_hold_u%0d", i), pulses[i], 0);

        // Request raised during reset: first accept on the first edge after release.
        RST = 1'b1;
        data_t[0] = 8'hA5; rdy_t[0] = 1'b1; exp_q[0].push_back(8'hA5);
        repeat (3) @(negedge CLK);
        chk(pulses[0] == 0, "no_accept_in_reset", pulses[0], 0);
        c = cyc;
        RST = 1'b0;
        wait_pulse(0, a);
        rdy_t[0] = 1'b0;
        chk(a - c == 1, "accept_latency", a - c, 1);
        repeat (110) @(negedge CLK);
        chk(pulses[0] == 1, "single_pulse_count", pulses[0], 1);

        fork
            begin int x; accept_byte(1, 8'h55, x); rdy_t[1] = 1'b0; end
            begin int x; accept_byte(2, 8'h55, x); rdy_t[2] = 1'b0; end
            begin int x; accept_byte(3, 8'h55, x); rdy_t[3] = 1'b0; end
        join
        repeat (140) @(negedge CLK);
        for (int i = 1; i < NI; i++)
            chk(pulses[i] == 1, $sformatf("parity_pulse_u%0d", i), pulses[i], 1);

        p0 = pulses[0];
        accept_byte(0, 8'h0D, a1);
        accept_byte(0, 8'h0A, a2);
        rdy_t[0] = 1'b0;
        chk(a2 - a1 == 100, "b2b_spacing", a2 - a1, 100);
        repeat (120) @(negedge CLK);
        chk(pulses[0] - p0 == 2, "b2b_count", pulses[0] - p0, 2);

        p0 = pulses[0];
        accept_byte(0, 8'h3C, a);
        repeat (29) @(negedge CLK);
        data_t[0] = 8'hFF; rdy_t[0] = 1'b0;
        repeat (130) @(negedge CLK);
        chk(pulses[0] - p0 == 1, "midframe_drop_count", pulses[0] - p0, 1);

        p0 = pulses[0];
        accept_byte(0, 8'h00, a);
        rdy_t[0] = 1'b0;
        repeat (44) @(negedge CLK);
        pre = txd[0];
        #2 RST = 1'b1;
        #1;
        chk(pre === 1'b0, "txd_low_before_reset", int'(pre), 0);
        chk(txd[0] === 1'b1 && busy[0] === 1'b0, "async_reset_line",
            int'({txd[0], busy[0]}), 2);
        data_t[0] = 8'h81; rdy_t[0] = 1'b1; exp_q[0].push_back(8'h81);
        repeat (3) @(negedge CLK);
        chk(pulses[0] - p0 == 1, "no_rdy_from_reset", pulses[0] - p0, 1);
        RST = 1'b0;
        wait_pulse(0, a);
        rdy_t[0] = 1'b0;
        repeat (110) @(negedge CLK);
        chk(pulses[0] - p0 == 2, "post_reset_frame", pulses[0] - p0, 2);

        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
            rand_run(3);
        join

        repeat (50) @(negedge CLK);
        for (int i = 0; i < NI; i++)
            chk(exp_q[i].size() == 0, $sformatf("queue_empty_u%0d", i), exp_q[i].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
